// File: rtl/sa_search_param.sv
// Successive-approximation search: finds the largest x with f(x) <= target,
// one bit per clock MSB first, with optional round-to-nearest and abort.
module sa_search_param #(
  parameter int XW       = 8,
  parameter int YW       = 10,
  parameter int GAIN     = 4,
  parameter int SQ_SHIFT = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic          round_en,
  input  logic [YW-1:0] target,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  localparam int IW = (XW > 1) ? $clog2(XW) : 1;
  // Wide enough for x*x or x*GAIN without overflow before saturation.
  localparam int PW = 2 * XW + 32;
  localparam logic [PW-1:0] YMAX = {{(PW-YW){1'b0}}, {YW{1'b1}}};

  typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;

  state_t        state;
  logic [YW-1:0] tgt;
  logic          mode_l;
  logic          round_l;
  logic [XW-1:0] acc;
  logic [IW-1:0] idx;

  logic [XW-1:0] trial;
  logic [XW-1:0] acc_inc;
  logic [YW-1:0] f_trial;
  logic [YW-1:0] f_lo;
  logic [YW-1:0] f_hi;
  logic          round_up;

  // Transfer function, saturated so it stays monotone after truncation.
  function automatic logic [YW-1:0] f_sat(input logic [XW-1:0] v, input logic sq);
    logic [PW-1:0] p;
    if (sq) p = (PW'(v) * PW'(v)) >> SQ_SHIFT;
    else    p = PW'(v) * PW'(GAIN);
    if (p > YMAX) return {YW{1'b1}};
    return p[YW-1:0];
  endfunction

  // Step up only when the upper neighbour is strictly closer; ties stay low.
  function automatic logic round_sel(input logic en, input logic [XW-1:0] a,
                                     input logic [YW-1:0] lo, input logic [YW-1:0] hi,
                                     input logic [YW-1:0] t);
    logic [YW:0] d_hi;
    logic [YW:0] d_lo;
    d_hi = {1'b0, hi} - {1'b0, t};
    d_lo = {1'b0, t} - {1'b0, lo};
    return en && (a != {XW{1'b1}}) && (d_hi < d_lo);
  endfunction

  always_comb begin
    trial    = acc | (XW'(1) << idx);
    acc_inc  = acc + XW'(1);
    f_trial  = f_sat(trial, mode_l);
    f_lo     = f_sat(acc, mode_l);
    f_hi     = f_sat(acc_inc, mode_l);
    round_up = round_sel(round_l, acc, f_lo, f_hi, tgt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tgt     <= '0;
      mode_l  <= 1'b0;
      round_l <= 1'b0;
      acc     <= '0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            tgt     <= target;
            mode_l  <= mode;
            round_l <= round_en;
            acc     <= '0;
            idx     <= IW'(XW - 1);
            busy    <= 1'b1;
            state   <= SEARCH;
          end
        end
        SEARCH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (f_trial <= tgt) acc <= trial;
            if (idx == '0) state <= FINISH;
            else           idx   <= idx - IW'(1);
          end
        end
        FINISH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            x     <= round_up ? acc_inc : acc;
            y     <= round_up ? f_hi : f_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_search_param.sv
// Directed bench for sa_search_param with hand-computed results.
module tb_sa_search_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       mode;
  logic       round_en;
  logic [9:0] target;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [9:0] y;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sa_search_param #(.XW(8), .YW(10), .GAIN(4), .SQ_SHIFT(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .round_en (round_en),
    .target   (target),
    .busy     (busy),
    .done     (done),
    .x        (x),
    .y        (y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; start is seen by the next rising edge.
  task automatic kick(input logic [9:0] t, input logic m, input logic r);
    target   = t;
    mode     = m;
    round_en = r;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [7:0] ex, input logic [9:0] ey,
                           input int lat);
    int cyc;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_x"}, {24'b0, x}, {24'b0, ex});
    chk({tag, "_y"}, {22'b0, y}, {22'b0, ey});
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic no_done(input string tag);
    int seen;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; round_en = 1'b0; target = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_x", {24'b0, x}, 32'd0);
    chk("rst_y", {22'b0, y}, 32'd0);
    reset = 1'b0;

    kick(10'd550, 1'b0, 1'b0);
    wait_done("lin550", 8'd137, 10'd548, 9);
    // New start issued in the done cycle.
    kick(10'd800, 1'b0, 1'b0);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    wait_done("lin800", 8'd200, 10'd800, 9);

    kick(10'd551, 1'b0, 1'b1);
    wait_done("rnd551", 8'd138, 10'd552, 9);
    kick(10'd550, 1'b0, 1'b1);
    wait_done("rnd_tie", 8'd137, 10'd548, 9);

    kick(10'd550, 1'b1, 1'b0);
    wait_done("sq_floor", 8'd187, 10'd546, 9);
    kick(10'd550, 1'b1, 1'b1);
    wait_done("sq_round", 8'd188, 10'd552, 9);

    kick(10'd0, 1'b0, 1'b0);
    wait_done("zero", 8'd0, 10'd0, 9);
    kick(10'd1023, 1'b0, 1'b1);
    wait_done("allones", 8'd255, 10'd1020, 9);

    // Abort mid-search keeps the previous result.
    kick(10'd300, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    no_done("abort_no_done");
    chk("abort_x", {24'b0, x}, 32'd255);
    chk("abort_y", {22'b0, y}, 32'd1020);
    kick(10'd550, 1'b0, 1'b0);
    wait_done("after_abort", 8'd137, 10'd548, 9);

    // Abort together with start in idle blocks the start.
    @(negedge clk);
    target = 10'd800; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {31'b0, busy}, 32'd0);
    no_done("abort_start_no_done");

    // Restart and input changes mid-search are ignored.
    kick(10'd1000, 1'b0, 1'b0);
    target = 10'd100; mode = 1'b1; round_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", 8'd250, 10'd1000, 7);

    // Reset mid-search clears results with no done.
    kick(10'd550, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_x", {24'b0, x}, 32'd0);
    chk("midrst_y", {22'b0, y}, 32'd0);
    no_done("midrst_no_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
